discrete_latch_mapper: RTL and testbench

- Parametrised successor to the single-latch discrete NES mappers (AxROM-class).
- One write latch at $8000-$FFFF selects among five discrete board modes at run time: AxROM, BNROM, GxROM, UxROM and CNROM.
- Adds bus-conflict emulation, a consecutive-write (RMW) filter and save-state access.
- Sits between the CPU/PPU bus decode and the PRG/CHR/SRAM memory controllers.

---
 rtl/discrete_latch_mapper_pkg.sv | 28 ++
 rtl/discrete_latch_mapper_bank.sv | 49 ++++
 rtl/discrete_latch_mapper.sv | 155 +++++++++++++++
 tb/tb_discrete_latch_mapper.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/discrete_latch_mapper_pkg.sv
// Shared types for discrete_latch_mapper: board-mode enum, save-state
// register indices and the cfg_sub -> mode decode.
package discrete_latch_mapper_pkg;

  typedef enum logic [2:0] {
    MODE_AXROM = 3'd0,
    MODE_BNROM = 3'd1,
    MODE_GXROM = 3'd2,
    MODE_UXROM = 3'd3,
    MODE_CNROM = 3'd4
  } mode_e;

  localparam logic [7:0] SST_IDX_INNER  = 8'd0;
  localparam logic [7:0] SST_IDX_EXT    = 8'd1;
  localparam logic [7:0] SST_IDX_MAPIDX = 8'd127;

  // Undefined board codes (5-7) fall back to AxROM behaviour.
  function automatic mode_e decode_mode(input logic [2:0] sub);
    case (sub)
      3'd1:    return MODE_BNROM;
      3'd2:    return MODE_GXROM;
      3'd3:    return MODE_UXROM;
      3'd4:    return MODE_CNROM;
      default: return MODE_AXROM;
    endcase
  endfunction

endpackage

// File: rtl/discrete_latch_mapper_bank.sv
// discrete_bank_decode: combinational PRG/CHR/mirroring address mux.
// Takes the latched bank state and the current board mode; holds no state.
module discrete_bank_decode
  import discrete_latch_mapper_pkg::*;
#(
  parameter int PRG_BANK_W = 4,
  parameter int CHR_BANK_W = 2,
  parameter int OUTER_W    = 2
) (
  input  mode_e                              mode,
  input  logic [PRG_BANK_W-1:0]              inner_prg,
  input  logic [CHR_BANK_W-1:0]              inner_chr,
  input  logic                               mir_bit,
  input  logic [OUTER_W-1:0]                 outer,
  input  logic [14:0]                        cpu_addr,
  input  logic [12:0]                        ppu_addr,
  output logic [PRG_BANK_W+OUTER_W+13:0]     prg_addr,
  output logic [CHR_BANK_W+OUTER_W+12:0]     chr_addr,
  output logic                               ciram_a10
);

  localparam int PW = PRG_BANK_W + 14;

  logic [PRG_BANK_W-1:0] bank16;
  logic [PW-1:0]         prg_in;
  logic [CHR_BANK_W-1:0] chr_bank;

  // PRG window: 32K modes drop the bank LSB slot below A15, UxROM pins the
  // upper 16K to the last bank, CNROM is a fixed 32K image.
  always_comb begin
    bank16 = cpu_addr[14] ? '1 : inner_prg;
    case (mode)
      MODE_UXROM: prg_in = {bank16, cpu_addr[13:0]};
      MODE_CNROM: prg_in = PW'(cpu_addr);
      default:    prg_in = PW'({inner_prg, cpu_addr});
    endcase
  end

  // Only GxROM and CNROM boards carry switchable CHR.
  always_comb begin
    chr_bank = '0;
    if (mode == MODE_GXROM || mode == MODE_CNROM) chr_bank = inner_chr;
  end

  assign prg_addr  = {outer, prg_in};
  assign chr_addr  = {outer, chr_bank, ppu_addr};
  assign ciram_a10 = (mode == MODE_AXROM) ? mir_bit : ppu_addr[10];

endmodule

// File: rtl/discrete_latch_mapper.sv
// discrete_latch_mapper: single write-latch discrete NES mapper covering
// AxROM/BNROM/GxROM/UxROM/CNROM, with bus-conflict AND, RMW double-write
// filter and save-state access. Registers clock on the falling edge of M2.
// Optional multicart outer bank register: define MULTICART_OUTER_EN.
module discrete_latch_mapper
  import discrete_latch_mapper_pkg::*;
#(
  parameter int PRG_BANK_W = 4,
  parameter int CHR_BANK_W = 2,
  parameter int OUTER_W    = 2
) (
  input  logic                           m2,
  input  logic                           map_rst_n,
  input  logic [2:0]                     cfg_sub,
  input  logic                           cfg_bus_cf,
  input  logic [7:0]                     cfg_map_idx,
  input  logic [15:0]                    cpu_addr,
  input  logic [7:0]                     cpu_data,
  input  logic                           cpu_rw,
  input  logic [7:0]                     prg_do,
  input  logic [13:0]                    ppu_addr,
  input  logic                           sst_act,
  input  logic                           sst_we,
  input  logic [7:0]                     sst_addr,
  input  logic [7:0]                     sst_dato,
  output logic [7:0]                     sst_di,
  output logic [PRG_BANK_W+OUTER_W+13:0] prg_addr,
  output logic [CHR_BANK_W+OUTER_W+12:0] chr_addr,
  output logic                           ciram_a10,
  output logic                           srm_ce
);

  mode_e                 mode;
  logic [PRG_BANK_W-1:0] inner_prg;
  logic [CHR_BANK_W-1:0] inner_chr;
  logic                  mir_bit;
  logic                  wr_prev;
  logic [OUTER_W-1:0]    outer;
  logic                  lock;
  logic                  srm_claim;
  logic [7:0]            d_val;
  logic                  latch_we;
  logic                  sram_hit;

  assign mode     = decode_mode(cfg_sub);
  assign d_val    = cfg_bus_cf ? (cpu_data & prg_do) : cpu_data;
  assign latch_we = cpu_addr[15] & ~cpu_rw & ~sst_act & ~wr_prev;
  assign sram_hit = (cpu_addr[15:13] == 3'b011);

  // Bank latch, RMW filter and save-state loads. wr_prev tracks accepted
  // writes only, so the write after a rejected one is taken again (the 1st
  // and 3rd of three back-to-back writes land).
  always_ff @(negedge m2 or negedge map_rst_n) begin
    if (!map_rst_n) begin
      inner_prg <= '0;
      inner_chr <= '0;
      mir_bit   <= 1'b0;
      wr_prev   <= 1'b0;
    end else if (sst_act) begin
      if (sst_we && sst_addr == SST_IDX_INNER) begin
        inner_prg <= PRG_BANK_W'(sst_dato[2:0]);
        mir_bit   <= sst_dato[4];
      end
      if (sst_we && sst_addr == SST_IDX_EXT)
        inner_chr <= CHR_BANK_W'(sst_dato[1:0]);
    end else begin
      wr_prev <= latch_we;
      if (latch_we) begin
        case (mode)
          MODE_AXROM: begin
            inner_prg <= PRG_BANK_W'(d_val[2:0]);
            mir_bit   <= d_val[4];
          end
          MODE_BNROM, MODE_UXROM: inner_prg <= PRG_BANK_W'(d_val);
          MODE_GXROM: begin
            inner_prg <= PRG_BANK_W'(d_val[5:4]);
            inner_chr <= CHR_BANK_W'(d_val[1:0]);
          end
          MODE_CNROM: inner_chr <= CHR_BANK_W'(d_val);
          default: ;
        endcase
      end
    end
  end

`ifdef MULTICART_OUTER_EN
  logic outer_we;
  assign outer_we = sram_hit & ~cpu_rw & ~sst_act & ~lock;

  // Outer bank register in the $6000-$7FFF window; once locked it stays
  // frozen until reset (save-state can still restore it).
  always_ff @(negedge m2 or negedge map_rst_n) begin
    if (!map_rst_n) begin
      outer <= '0;
      lock  <= 1'b0;
    end else if (sst_act) begin
      if (sst_we && sst_addr == SST_IDX_EXT) begin
        outer <= sst_dato[4 +: OUTER_W];
        lock  <= sst_dato[7];
      end
    end else if (outer_we) begin
      outer <= cpu_data[OUTER_W-1:0];
      lock  <= cpu_data[7];
    end
  end

  // While unlocked, writes to $6000-$7FFF belong to the outer register.
  assign srm_claim = ~cpu_rw & ~lock;
`else
  assign outer     = '0;
  assign lock      = 1'b0;
  assign srm_claim = 1'b0;
`endif

  assign srm_ce = sram_hit & ~srm_claim;

  logic [2:0] prg_lo;
  logic [1:0] chr_lo;
  logic [1:0] outer_lo;
  assign prg_lo   = 3'(inner_prg);
  assign chr_lo   = 2'(inner_chr);
  assign outer_lo = 2'(outer);

  // Save-state readback mux.
  always_comb begin
    sst_di = 8'hFF;
    case (sst_addr)
      SST_IDX_INNER:  sst_di = {3'd0, mir_bit, 1'b0, prg_lo};
      SST_IDX_EXT:    sst_di = {lock, 1'b0, outer_lo, 2'd0, chr_lo};
      SST_IDX_MAPIDX: sst_di = cfg_map_idx;
      default: ;
    endcase
  end

  discrete_bank_decode #(
    .PRG_BANK_W(PRG_BANK_W),
    .CHR_BANK_W(CHR_BANK_W),
    .OUTER_W   (OUTER_W)
  ) u_dec (
    .mode     (mode),
    .inner_prg(inner_prg),
    .inner_chr(inner_chr),
    .mir_bit  (mir_bit),
    .outer    (outer),
    .cpu_addr (cpu_addr[14:0]),
    .ppu_addr (ppu_addr[12:0]),
    .prg_addr (prg_addr),
    .chr_addr (chr_addr),
    .ciram_a10(ciram_a10)
  );

  logic unused_bits;
  assign unused_bits = ^{ppu_addr[13], sst_dato};

endmodule

// File: tb/tb_discrete_latch_mapper.sv
// Scoreboard bench for discrete_latch_mapper: stimulus pushes hand-computed
// expectations, a monitor pops one per M2 rising edge and compares.
module tb_discrete_latch_mapper;

  localparam logic [4:0] M_PRG = 5'd1, M_CHR = 5'd2, M_A10 = 5'd4,
                         M_SRM = 5'd8, M_SDI = 5'd16;

  logic        m2 = 1'b1;
  logic        map_rst_n;
  logic [2:0]  cfg_sub;
  logic        cfg_bus_cf;
  logic [7:0]  cfg_map_idx;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_rw;
  logic [7:0]  prg_do;
  logic [13:0] ppu_addr;
  logic        sst_act, sst_we;
  logic [7:0]  sst_addr, sst_dato;
  logic [7:0]  sst_di;
  logic [19:0] prg_addr;
  logic [16:0] chr_addr;
  logic        ciram_a10, srm_ce;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    logic [4:0] m;
    logic [19:0] prg;
    logic [16:0] chr;
    logic       a10;
    logic       srm;
    logic [7:0] sdi;
  } exp_t;
  exp_t sb[$];

  always #5 m2 = ~m2;

  discrete_latch_mapper dut (
    .m2(m2), .map_rst_n(map_rst_n), .cfg_sub(cfg_sub), .cfg_bus_cf(cfg_bus_cf),
    .cfg_map_idx(cfg_map_idx), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_rw(cpu_rw), .prg_do(prg_do), .ppu_addr(ppu_addr), .sst_act(sst_act),
    .sst_we(sst_we), .sst_addr(sst_addr), .sst_dato(sst_dato), .sst_di(sst_di),
    .prg_addr(prg_addr), .chr_addr(chr_addr), .ciram_a10(ciram_a10),
    .srm_ce(srm_ce)
  );

  task automatic cmp(input string nm, input string f, input logic [19:0] act,
                     input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the M2 rising edge, away from the
  // falling edge that updates the mapper registers.
  initial begin
    exp_t e;
    forever begin
      @(posedge m2);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.m[0]) cmp(e.nm, "prg_addr", prg_addr, e.prg);
        if (e.m[1]) cmp(e.nm, "chr_addr", {3'd0, chr_addr}, {3'd0, e.chr});
        if (e.m[2]) cmp(e.nm, "ciram_a10", {19'd0, ciram_a10}, {19'd0, e.a10});
        if (e.m[3]) cmp(e.nm, "srm_ce", {19'd0, srm_ce}, {19'd0, e.srm});
        if (e.m[4]) cmp(e.nm, "sst_di", {12'd0, sst_di}, {12'd0, e.sdi});
      end
    end
  end

  // One M2 cycle of CPU bus activity; launched just after the rising edge.
  task automatic drv(input logic [15:0] a, input logic rw, input logic [7:0] d);
    @(posedge m2); #1;
    cpu_addr = a; cpu_rw = rw; cpu_data = d;
  endtask

  task automatic chk(input string nm, input logic [4:0] m, input logic [19:0] prg,
                     input logic [16:0] chr, input logic a10, input logic srm,
                     input logic [7:0] sdi);
    exp_t e;
    e.nm = nm; e.m = m; e.prg = prg; e.chr = chr; e.a10 = a10; e.srm = srm; e.sdi = sdi;
    sb.push_back(e);
  endtask

  initial begin
    map_rst_n = 1'b0; cfg_sub = 3'd0; cfg_bus_cf = 1'b0; cfg_map_idx = 8'h5A;
    cpu_addr = 16'h8000; cpu_data = 8'h00; cpu_rw = 1'b1; prg_do = 8'hFF;
    ppu_addr = 14'h0400; sst_act = 1'b0; sst_we = 1'b0; sst_addr = 8'h00; sst_dato = 8'h00;

    drv(16'h8000, 1, 8'h00);
    chk("rst", 5'h1F, 20'h00000, 17'h00400, 1'b0, 1'b0, 8'h00);
    drv(16'h8000, 1, 8'h00); map_rst_n = 1'b1;

    // AxROM
    drv(16'h8000, 0, 8'h13); chk("ax_wr", M_PRG | M_A10, 20'h18000, 0, 1'b1, 0, 0);
    drv(16'hFFFC, 1, 8'h00); chk("ax_rd", M_PRG | M_SDI, 20'h1FFFC, 0, 0, 0, 8'h13);
    drv(16'h8000, 0, 8'h13); cfg_bus_cf = 1'b1; prg_do = 8'h05;
    chk("bus_cf", M_PRG | M_A10, 20'h08000, 0, 1'b0, 0, 0);
    drv(16'h8000, 1, 8'h00); cfg_bus_cf = 1'b0; prg_do = 8'hFF;
    chk("bus_cf_sdi", M_SDI, 0, 0, 0, 0, 8'h01);

    // UxROM
    drv(16'h8000, 1, 8'h00); cfg_sub = 3'd3;
    chk("ux_sw", M_PRG | M_A10, 20'h04000, 0, 1'b1, 0, 0);
    drv(16'h8000, 0, 8'h02); chk("ux_lo", M_PRG, 20'h08000, 0, 0, 0, 0);
    drv(16'hC000, 1, 8'h00); chk("ux_hi", M_PRG | M_CHR, 20'h3C000, 17'h00400, 0, 0, 0);
    drv(16'hBFFF, 1, 8'h00); chk("ux_lo_top", M_PRG, 20'h0BFFF, 0, 0, 0, 0);

    // RMW filter
    drv(16'h8000, 0, 8'h01); chk("rmw_1", M_PRG, 20'h04000, 0, 0, 0, 0);
    drv(16'h8000, 0, 8'h02); chk("rmw_2", M_PRG, 20'h04000, 0, 0, 0, 0);
    drv(16'h8000, 1, 8'h00);
    drv(16'h8000, 0, 8'h02); chk("rmw_3", M_PRG, 20'h08000, 0, 0, 0, 0);
    drv(16'h8000, 1, 8'h00);
    drv(16'h8000, 0, 8'h03); chk("b2b_1", M_PRG, 20'h0C000, 0, 0, 0, 0);
    drv(16'h8000, 0, 8'h04); chk("b2b_2", M_PRG, 20'h0C000, 0, 0, 0, 0);
    drv(16'h8000, 0, 8'h05); chk("b2b_3", M_PRG, 20'h14000, 0, 0, 0, 0);
    drv(16'h8000, 1, 8'h00);

    // GxROM, CNROM, fallback code, BNROM
    drv(16'h8000, 0, 8'h31); cfg_sub = 3'd2;
    chk("gx", M_PRG | M_CHR | M_A10, 20'h18000, 17'h02400, 1'b1, 0, 0);
    drv(16'h8000, 1, 8'h00); cfg_sub = 3'd4;
    chk("cn_sw", M_PRG | M_CHR, 20'h00000, 17'h02400, 0, 0, 0);
    drv(16'h8000, 0, 8'hFE); chk("cn_wr", M_CHR, 0, 17'h04400, 0, 0, 0);
    drv(16'hC000, 1, 8'h00); chk("cn_hi", M_PRG, 20'h04000, 0, 0, 0, 0);
    drv(16'h8000, 1, 8'h00); cfg_sub = 3'd6;
    chk("sub6_ax", M_PRG | M_CHR | M_A10, 20'h18000, 17'h00400, 1'b0, 0, 0);
    drv(16'h8000, 0, 8'h0F); cfg_sub = 3'd1;
    chk("bn_trunc", M_PRG | M_A10, 20'h38000, 0, 1'b1, 0, 0);
    drv(16'h8000, 1, 8'h00);

    // SRAM decode
    drv(16'h6000, 1, 8'h00); chk("srm_rd", M_SRM, 0, 0, 0, 1'b1, 0);
    drv(16'h5FFF, 1, 8'h00); chk("srm_lo", M_SRM, 0, 0, 0, 1'b0, 0);

    // Save-state
    drv(16'h8000, 0, 8'h01); cfg_sub = 3'd0;
    chk("pre_sst", M_PRG, 20'h08000, 0, 0, 0, 0);
    drv(16'h8000, 0, 8'h07); sst_act = 1'b1; sst_we = 1'b1; sst_addr = 8'd0; sst_dato = 8'h12;
    chk("sst_ld", M_PRG | M_A10 | M_SDI, 20'h10000, 0, 1'b1, 0, 8'h12);
    drv(16'h8000, 0, 8'h07); sst_we = 1'b0;
    chk("sst_cpu_ign", M_PRG | M_SDI, 20'h10000, 0, 0, 0, 8'h12);
    drv(16'h8000, 1, 8'h00); sst_addr = 8'd127; chk("sst_idx127", M_SDI, 0, 0, 0, 0, 8'h5A);
    drv(16'h8000, 1, 8'h00); sst_addr = 8'd1;   chk("sst_ext", M_SDI, 0, 0, 0, 0, 8'h02);
    drv(16'h8000, 1, 8'h00); sst_addr = 8'd5;   chk("sst_oth", M_SDI, 0, 0, 0, 0, 8'hFF);
    drv(16'h8000, 1, 8'h00); sst_we = 1'b1; sst_addr = 8'd1; sst_dato = 8'h03;
    chk("sst_ext_ld", M_SDI, 0, 0, 0, 0, 8'h03);
    drv(16'h8000, 0, 8'h05); sst_act = 1'b0; sst_we = 1'b0; sst_addr = 8'd0;
    chk("sst_hold", M_PRG, 20'h10000, 0, 0, 0, 0);
    drv(16'h8000, 0, 8'h05); chk("post_sst", M_PRG | M_A10, 20'h28000, 0, 1'b0, 0, 0);
    drv(16'h8000, 1, 8'h00);

`ifdef MULTICART_OUTER_EN
    drv(16'h6000, 0, 8'h01); chk("mc_claim", M_PRG | M_SRM, 20'h6E000, 0, 0, 1'b0, 0);
    drv(16'h6000, 0, 8'h81); chk("mc_lock", M_SRM, 0, 0, 0, 1'b1, 0);
    drv(16'h6000, 0, 8'h02); sst_addr = 8'd1;
    chk("mc_locked", M_PRG | M_SDI, 20'h6E000, 0, 0, 0, 8'h93);
    drv(16'h8000, 1, 8'h00); chk("mc_prg", M_PRG, 20'h68000, 0, 0, 0, 0);
`else
    drv(16'h7FFF, 0, 8'h81); chk("sram_wr", M_PRG | M_SRM, 20'h2FFFF, 0, 0, 1'b1, 0);
    drv(16'h8000, 1, 8'h00); sst_addr = 8'd1;
    chk("no_outer", M_PRG | M_SDI, 20'h28000, 0, 0, 0, 8'h03);
`endif

    // Reset asserted in the middle of a latch write
    drv(16'h8000, 0, 8'h07); map_rst_n = 1'b0; sst_addr = 8'd1;
    chk("rst_wr", M_PRG | M_A10 | M_SDI, 20'h00000, 0, 1'b0, 0, 8'h00);
    drv(16'h8000, 1, 8'h00); map_rst_n = 1'b1; sst_addr = 8'd0;
    chk("rst_post", M_PRG | M_SDI, 20'h00000, 0, 0, 0, 8'h00);
    drv(16'h8000, 0, 8'h02); chk("rst_wr_ok", M_PRG, 20'h10000, 0, 0, 0, 0);
    drv(16'h8000, 1, 8'h00);

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge m2); #1;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
